skolem_checker: RTL

SKOLEM_CHECKER -- requirements
Module: skolem_checker

---
 rtl/skolem_checker_pkg.sv | 25 ++
 rtl/skolem_spec_eval.sv | 18 +
 rtl/skolem_checker.sv | 124 ++++++++++++
 3 files changed

// File: rtl/skolem_checker_pkg.sv
// Shared types and helpers for the Skolem-function checker: FSM states,
// vector geometry and the split of a universal vector into its a/b nibbles.
package skolem_checker_pkg;

    localparam int NIB_W     = 4;
    localparam int VEC_W     = 2 * NIB_W;
    localparam int NVEC_FULL = 1 << VEC_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    function automatic logic [NIB_W-1:0] vec_a(input logic [VEC_W-1:0] v);
        return v[NIB_W-1:0];
    endfunction

    function automatic logic [NIB_W-1:0] vec_b(input logic [VEC_W-1:0] v);
        return v[VEC_W-1:NIB_W];
    endfunction

endpackage

// File: rtl/skolem_spec_eval.sv
// Reference relation for the existential output: a logically shifted right by
// b[1:0], compared as a signed nibble against signed b.
module skolem_spec_eval
    import skolem_checker_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic             e
);

    logic [NIB_W-1:0] shifted;

    always_comb begin
        shifted = a >> b[1:0];
        e       = $signed(shifted) > $signed(b);
    end

endmodule

// File: rtl/skolem_checker.sv
// Sweeps every universal vector through an external Skolem candidate, waits a
// bounded time for its witness and tallies matches against the reference relation.
module skolem_checker
    import skolem_checker_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int NVEC    = NVEC_FULL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [VEC_W-1:0] vec_o,
    output logic             vec_valid,
    input  logic             wit_valid,
    input  logic             wit_bit,
    output logic             busy,
    output logic             done,
    output logic [8:0]       pass_cnt,
    output logic [8:0]       fail_cnt,
    output logic [VEC_W-1:0] first_fail,
    output logic             fail_seen
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NVEC - 1);

    state_t           state;
    logic [VEC_W-1:0] idx;
    logic [TW-1:0]    wcnt;
    logic             wit_q;
    logic             timed_out;
    logic             exp_e;
    logic             match;

    skolem_spec_eval u_spec (
        .a (vec_a(vec_o)),
        .b (vec_b(vec_o)),
        .e (exp_e)
    );

    assign match = !timed_out && (wit_q == exp_e);

    // vec_o/vec_valid are loaded on the edge that enters DRIVE, so the
    // candidate sees a stable vector for the whole DRIVE+WAIT window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            wcnt       <= '0;
            wit_q      <= 1'b0;
            timed_out  <= 1'b0;
            vec_o      <= '0;
            vec_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        pass_cnt  <= '0;
                        fail_cnt  <= '0;
                        fail_seen <= 1'b0;
                        vec_o     <= '0;
                        vec_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    wcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (wit_valid) begin
                        wit_q     <= wit_bit;
                        timed_out <= 1'b0;
                        vec_valid <= 1'b0;
                        state     <= S_EVAL;
                    end else if (wcnt == TW'(TIMEOUT)) begin
                        timed_out <= 1'b1;
                        vec_valid <= 1'b0;
                        state     <= S_EVAL;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    if (match) begin
                        pass_cnt <= pass_cnt + 9'd1;
                    end else begin
                        fail_cnt <= fail_cnt + 9'd1;
                        if (!fail_seen) begin
                            first_fail <= vec_o;
                            fail_seen  <= 1'b1;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx       <= idx + 1'b1;
                        vec_o     <= idx + 1'b1;
                        vec_valid <= 1'b1;
                        state     <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
